// File: rtl/mc_control_alu.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_alu
// Brief    : Multi-cycle MIPS control FSM, control decoder and 32-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_alu (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [2:0]  CurState,
    output logic [2:0]  NextState,
    output logic [31:0] Y,
    output logic        Zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        RegWre,
    output logic        mRD,
    output logic        mWR,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        DBDataSrc,
    output logic        WrRegDSrc,
    output logic        ExtSel,
    output logic [1:0]  RegDst,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_SEXE = 3'b010,
        S_MEM  = 3'b011,
        S_CWB  = 3'b100,
        S_BEXE = 3'b101,
        S_AEXE = 3'b110,
        S_AWB  = 3'b111
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_rtype;
    logic w_add, w_sub, w_and, w_or, w_slt, w_sll, w_jr;
    logic w_addiu, w_slti, w_andi, w_ori, w_xori;
    logic w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_halt;
    logic w_r_alu, w_i_alu, w_legal, w_illegal, w_pc_only;

    assign w_rtype = (OpCode == 6'b000000);
    assign w_add   = w_rtype && (Funct == 6'b100000);
    assign w_sub   = w_rtype && (Funct == 6'b100010);
    assign w_and   = w_rtype && (Funct == 6'b100100);
    assign w_or    = w_rtype && (Funct == 6'b100101);
    assign w_slt   = w_rtype && (Funct == 6'b101010);
    assign w_sll   = w_rtype && (Funct == 6'b000000);
    assign w_jr    = w_rtype && (Funct == 6'b001000);
    assign w_addiu = (OpCode == 6'b001001);
    assign w_slti  = (OpCode == 6'b001010);
    assign w_andi  = (OpCode == 6'b001100);
    assign w_ori   = (OpCode == 6'b001101);
    assign w_xori  = (OpCode == 6'b001110);
    assign w_lw    = (OpCode == 6'b100011);
    assign w_sw    = (OpCode == 6'b101011);
    assign w_beq   = (OpCode == 6'b000100);
    assign w_bne   = (OpCode == 6'b000101);
    assign w_j     = (OpCode == 6'b000010);
    assign w_jal   = (OpCode == 6'b000011);
    assign w_halt  = (OpCode == 6'b111111);

    assign w_r_alu   = w_add | w_sub | w_and | w_or | w_slt | w_sll;
    assign w_i_alu   = w_addiu | w_slti | w_andi | w_ori | w_xori;
    assign w_legal   = w_r_alu | w_jr | w_i_alu | w_lw | w_sw | w_beq | w_bne
                     | w_j | w_jal | w_halt;
    assign w_illegal = ~w_legal;
    // Instructions that finish in ID: only the PC changes (illegal acts as NOP)
    assign w_pc_only = w_j | w_jal | w_jr | w_illegal;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:   w_next = w_halt ? S_IF : S_ID;
            S_ID: begin
                if (w_pc_only || w_halt)  w_next = S_IF;
                else if (w_beq || w_bne)  w_next = S_BEXE;
                else if (w_lw || w_sw)    w_next = S_SEXE;
                else                      w_next = S_AEXE;
            end
            S_SEXE: w_next = S_MEM;
            S_MEM:  w_next = w_lw ? S_CWB : S_IF;
            S_AEXE: w_next = S_AWB;
            S_AWB:  w_next = S_IF;
            S_BEXE: w_next = S_IF;
            S_CWB:  w_next = S_IF;
            default: w_next = S_IF;
        endcase
    end

    assign CurState  = r_state;
    assign NextState = w_next;
    assign InsMemRW  = 1'b1;

    always_comb begin
        IRWre  = (r_state == S_IF);
        PCWre  = ((r_state == S_ID)  && w_pc_only)
               || (r_state == S_BEXE)
               || (r_state == S_AWB)
               || ((r_state == S_MEM) && w_sw)
               || (r_state == S_CWB);
        RegWre = (r_state == S_AWB) || (r_state == S_CWB)
               || ((r_state == S_ID) && w_jal);
        mRD    = (r_state == S_MEM) && w_lw;
        mWR    = (r_state == S_MEM) && w_sw;
    end

    always_comb begin
        ALUOp = 3'b000;
        if (w_sub || w_beq || w_bne)  ALUOp = 3'b001;
        else if (w_sll)               ALUOp = 3'b010;
        else if (w_or || w_ori)       ALUOp = 3'b011;
        else if (w_and || w_andi)     ALUOp = 3'b100;
        else if (w_slt || w_slti)     ALUOp = 3'b101;
        else if (w_xori)              ALUOp = 3'b110;

        ALUSrcA   = w_sll;
        ALUSrcB   = w_i_alu | w_lw | w_sw;
        ExtSel    = w_addiu | w_slti | w_lw | w_sw | w_beq | w_bne;
        DBDataSrc = w_lw;
        WrRegDSrc = ~w_jal;

        RegDst = 2'b00;
        if (w_i_alu || w_lw)          RegDst = 2'b01;
        else if (w_r_alu || w_jr)     RegDst = 2'b10;

        PCSrc = 2'b00;
        if (w_j || w_jal)                       PCSrc = 2'b11;
        else if (w_jr)                          PCSrc = 2'b10;
        else if ((w_beq && Zero) || (w_bne && !Zero)) PCSrc = 2'b01;
    end

    always_comb begin
        Y = 32'd0;
        case (ALUOp)
            3'b000: Y = A + B;
            3'b001: Y = A - B;
            3'b010: Y = B << A[4:0];
            3'b011: Y = A | B;
            3'b100: Y = A & B;
            3'b101: Y = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            3'b110: Y = A ^ B;
            3'b111: Y = (A < B) ? 32'd1 : 32'd0;
            default: Y = 32'd0;
        endcase
    end

    assign Zero = (Y == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_mc_control_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_alu
// Brief    : Scoreboard bench for mc_control_alu with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_alu;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  OpCode = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  CurState, NextState, ALUOp;
    logic [31:0] Y;
    logic        Zero, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
    logic        ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0]  RegDst, PCSrc;

    mc_control_alu dut (
        .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .A(A), .B(B),
        .CurState(CurState), .NextState(NextState), .Y(Y), .Zero(Zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
        .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp)
    );

    always #5 CLK = ~CLK;

    localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_SLT = 4, M_SLL = 5,
                   M_JR = 6, M_ADDIU = 7, M_SLTI = 8, M_ANDI = 9, M_ORI = 10,
                   M_XORI = 11, M_LW = 12, M_SW = 13, M_BEQ = 14, M_BNE = 15,
                   M_J = 16, M_JAL = 17, M_ILL = 18, M_HALT = 19;

    typedef struct {
        logic [2:0]  st;
        logic [2:0]  nst;
        logic [5:0]  strobes;   // PCWre IRWre InsMemRW RegWre mRD mWR
        logic [4:0]  lvl;       // ALUSrcA ALUSrcB DBDataSrc WrRegDSrc ExtSel
        logic [1:0]  pcsrc;
        logic        chk_y;
        logic [31:0] y;
        logic [2:0]  aluop;
        logic        chk_rd;
        logic [1:0]  regdst;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] enc(input int m);
        case (m)
            M_ADD:   return {6'b000000, 6'b100000};
            M_SUB:   return {6'b000000, 6'b100010};
            M_AND:   return {6'b000000, 6'b100100};
            M_OR:    return {6'b000000, 6'b100101};
            M_SLT:   return {6'b000000, 6'b101010};
            M_SLL:   return {6'b000000, 6'b000000};
            M_JR:    return {6'b000000, 6'b001000};
            M_ADDIU: return {6'b001001, 6'b000000};
            M_SLTI:  return {6'b001010, 6'b000000};
            M_ANDI:  return {6'b001100, 6'b000000};
            M_ORI:   return {6'b001101, 6'b000000};
            M_XORI:  return {6'b001110, 6'b000000};
            M_LW:    return {6'b100011, 6'b000000};
            M_SW:    return {6'b101011, 6'b000000};
            M_BEQ:   return {6'b000100, 6'b000000};
            M_BNE:   return {6'b000101, 6'b000000};
            M_J:     return {6'b000010, 6'b000000};
            M_JAL:   return {6'b000011, 6'b000000};
            default: return {6'b111111, 6'b000000};
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        for (int m = 0; m < M_ILL; m++) begin
            logic [11:0] e;
            e = enc(m);
            if (e[11:6] == op && (op != 6'd0 || e[5:0] == fn)) return 1'b1;
        end
        return (op == 6'b111111);
    endfunction

    // Reference ALU result and function code per mnemonic
    function automatic logic [31:0] ref_y(input int m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            M_ADD, M_ADDIU, M_LW, M_SW: return a + b;
            M_SUB, M_BEQ, M_BNE:        return a - b;
            M_AND, M_ANDI:              return a & b;
            M_OR, M_ORI:                return a | b;
            M_XORI:                     return a ^ b;
            M_SLT, M_SLTI:              return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            M_SLL:                      return b << a[4:0];
            default:                    return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_op(input int m);
        case (m)
            M_SUB, M_BEQ, M_BNE: return 3'd1;
            M_SLL:               return 3'd2;
            M_OR, M_ORI:         return 3'd3;
            M_AND, M_ANDI:       return 3'd4;
            M_SLT, M_SLTI:       return 3'd5;
            M_XORI:              return 3'd6;
            default:             return 3'd0;
        endcase
    endfunction

    // Runs one instruction from IF; max_steps truncates the walk early
    task automatic issue(input int m, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int max_steps);
        logic [2:0] path[$];
        exp_t e;
        bit writes_reg;
        OpCode = op; Funct = fn; A = a; B = b;
        if (m inside {M_J, M_JAL, M_JR, M_ILL})   path = '{3'd0, 3'd1};
        else if (m inside {M_BEQ, M_BNE})         path = '{3'd0, 3'd1, 3'd5};
        else if (m == M_LW)                       path = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        else if (m == M_SW)                       path = '{3'd0, 3'd1, 3'd2, 3'd3};
        else                                      path = '{3'd0, 3'd1, 3'd6, 3'd7};
        writes_reg = (m <= M_SLL) || (m >= M_ADDIU && m <= M_LW) || (m == M_JAL);
        for (int k = 0; k < path.size() && k < max_steps; k++) begin
            bit last;
            last       = (k == path.size() - 1);
            e.st       = path[k];
            e.nst      = last ? 3'd0 : path[k+1];
            e.strobes  = {last, k == 0, 1'b1, writes_reg && last,
                          m == M_LW && path[k] == 3'd3, m == M_SW && path[k] == 3'd3};
            e.lvl      = {m == M_SLL,
                          m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW},
                          m == M_LW, m != M_JAL,
                          m inside {M_ADDIU, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE}};
            if (m inside {M_J, M_JAL})                       e.pcsrc = 2'b11;
            else if (m == M_JR)                              e.pcsrc = 2'b10;
            else if ((m == M_BEQ && a == b) || (m == M_BNE && a != b)) e.pcsrc = 2'b01;
            else                                             e.pcsrc = 2'b00;
            e.chk_y    = !(m inside {M_J, M_JAL, M_JR, M_ILL});
            e.y        = ref_y(m, a, b);
            e.aluop    = ref_op(m);
            e.chk_rd   = (m <= M_SLL) || (m >= M_ADDIU && m <= M_LW) || (m == M_JAL);
            e.regdst   = (m == M_JAL) ? 2'b00 : (m <= M_SLL) ? 2'b10 : 2'b01;
            q.push_back(e);
            @(posedge CLK); #1;
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        #1;
        chk("async_rst_state", {29'd0, CurState}, 32'd0);
        chk("async_rst_wr", {30'd0, RegWre, PCWre}, 32'd0);
        chk("async_rst_irwre", {31'd0, IRWre}, 32'd1);
        #1;
        RST = 1'b1;
    endtask

    // Monitor: compares every cycle that has a pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("CurState", {29'd0, CurState}, {29'd0, e.st});
                chk("NextState", {29'd0, NextState}, {29'd0, e.nst});
                chk("strobes", {26'd0, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR},
                    {26'd0, e.strobes});
                chk("selects", {27'd0, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel},
                    {27'd0, e.lvl});
                chk("PCSrc", {30'd0, PCSrc}, {30'd0, e.pcsrc});
                if (e.chk_y) begin
                    chk("Y", Y, e.y);
                    chk("Zero", {31'd0, Zero}, {31'd0, e.y == 32'd0});
                    chk("ALUOp", {29'd0, ALUOp}, {29'd0, e.aluop});
                end
                if (e.chk_rd) chk("RegDst", {30'd0, RegDst}, {30'd0, e.regdst});
            end
        end
    end

    initial begin
        logic [11:0] en;
        logic [31:0] ra, rb;
        logic [5:0]  iop, ifn;
        int          m;
        exp_t        h;

        #1 RST = 1'b0;
        #1;
        chk("rst_state_before_clk", {29'd0, CurState}, 32'd0);
        en = enc(M_ADD);
        OpCode = en[11:6]; Funct = en[5:0];
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_state", {29'd0, CurState}, 32'd0);
        chk("rst_strobes", {26'd0, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}, 32'b011000);
        chk("rst_regdst", {30'd0, RegDst}, 32'd2);
        @(posedge CLK); #2;
        RST = 1'b1;

        en = enc(M_ADD);  issue(M_ADD,  en[11:6], en[5:0], 32'd5, 32'd7, 99);
        en = enc(M_LW);   issue(M_LW,   en[11:6], en[5:0], 32'h100, 32'd4, 99);
        en = enc(M_BEQ);  issue(M_BEQ,  en[11:6], en[5:0], 32'd9, 32'd9, 99);
        en = enc(M_BEQ);  issue(M_BEQ,  en[11:6], en[5:0], 32'd9, 32'd8, 99);
        en = enc(M_JAL);  issue(M_JAL,  en[11:6], en[5:0], 32'd3, 32'd4, 99);
        en = enc(M_SLL);  issue(M_SLL,  en[11:6], en[5:0], 32'd4, 32'd1, 99);
        en = enc(M_SLT);  issue(M_SLT,  en[11:6], en[5:0], 32'hFFFFFFFF, 32'd1, 99);
        en = enc(M_SUB);  issue(M_SUB,  en[11:6], en[5:0], 32'd0, 32'd1, 99);
        en = enc(M_SW);   issue(M_SW,   en[11:6], en[5:0], 32'h20, 32'h8, 99);

        // Reset while in aEXE
        en = enc(M_ADD);  issue(M_ADD,  en[11:6], en[5:0], 32'd1, 32'd2, 2);
        chk("in_aexe", {29'd0, CurState}, 32'd6);
        pulse_reset();

        for (int n = 0; n < 150; n++) begin
            m = $urandom_range(0, M_ILL);
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = $urandom_range(0, 40);
                2:       ra = 32'h80000000 ^ $urandom_range(0, 3);
                default: ra = 32'hFFFFFFFF - $urandom_range(0, 3);
            endcase
            rb = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
            if (m inside {M_BEQ, M_BNE} && $urandom_range(0, 1) != 0) rb = ra;
            if (m == M_ILL) begin
                do begin
                    iop = 6'($urandom_range(0, 63));
                    ifn = 6'($urandom_range(0, 63));
                end while (is_legal(iop, ifn));
            end else begin
                en = enc(m);
                iop = en[11:6];
                ifn = en[5:0];
            end
            issue(m, iop, ifn, ra, rb, 99);
        end

        // halt holds in IF until reset
        en = enc(M_HALT);
        OpCode = en[11:6]; Funct = en[5:0];
        h.st = 3'd0; h.nst = 3'd0; h.strobes = 6'b011000; h.lvl = 5'b00010;
        h.pcsrc = 2'b00; h.chk_y = 1'b0; h.y = 32'd0; h.aluop = 3'd0;
        h.chk_rd = 1'b0; h.regdst = 2'b00;
        for (int k = 0; k < 10; k++) begin
            q.push_back(h);
            @(posedge CLK); #1;
        end
        pulse_reset();
        en = enc(M_ORI);  issue(M_ORI,  en[11:6], en[5:0], 32'hF0, 32'h0F, 99);

        @(negedge CLK); #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_alu.md
# mc_control_alu

Control-and-execute core of the multi-cycle MIPS CPU: a 3-bit state register, next-state logic, the control-signal decoder and the 32-bit ALU in one block. It sits between the instruction memory/IR (supplies OpCode/Funct) and the datapath muxes, PC, register file and data memory. It drives every datapath enable and select. The ALU's Zero flag feeds the branch decision internally.

## Interface
- No parameters.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- OpCode  in  6  instruction[31:26].
- Funct  in  6  instruction[5:0].
- A  in  32  ALU operand A (rs or zero-extended sa, selected externally).
- B  in  32  ALU operand B (rt or extended immediate).
- CurState  out  3  registered state.
- NextState  out  3  combinational next state.
- Y  out  32  ALU result.
- Zero  out  1  1 when Y==0.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR write enable.
- InsMemRW  out  1  instruction-memory read, constant 1.
- RegWre  out  1  register-file write enable.
- mRD  out  1  data-memory read.
- mWR  out  1  data-memory write.
- ALUSrcA  out  1  0 = rs, 1 = sa.
- ALUSrcB  out  1  0 = rt, 1 = extended immediate.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DBDR.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- ALUOp  out  3  ALU function.

## Operation
- Instruction set:
  - R-type (OpCode 000000), by Funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - Others, by OpCode: addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, halt 111111.
  - Any other encoding is illegal.
- States: IF 000, ID 001, sEXE 010, MEM 011, cWB 100, bEXE 101, aEXE 110, aWB 111.
- Transitions:
  - IF→ID, except halt: IF→IF.
  - ID→IF for j, jal, jr and illegal encodings.
  - ID→bEXE for beq/bne; ID→sEXE for lw/sw; ID→aEXE for everything else.
  - aEXE→aWB→IF.
  - bEXE→IF.
  - sEXE→MEM; MEM→IF for sw, MEM→cWB for lw; cWB→IF.
- ALUOp and ALU result Y:
  - 000: A+B (add, addiu, lw, sw).
  - 001: A−B (sub, beq, bne).
  - 010: B<<A[4:0] (sll).
  - 011: A|B (or, ori).
  - 100: A&B (and, andi).
  - 101: signed A<B ? 1 : 0 (slt, slti).
  - 110: A^B (xori).
  - 111: unsigned A<B ? 1 : 0.
  - Arithmetic wraps modulo 2^32; no overflow flag.
- Level decodes, valid in every state, functions of OpCode/Funct only:
  - ALUOp as above.
  - ALUSrcA=1 for sll only.
  - ALUSrcB=1 for addiu, slti, andi, ori, xori, lw, sw.
  - ExtSel=1 for addiu, slti, lw, sw, beq, bne.
  - RegDst: 00 jal, 01 I-type ALU ops and lw, 10 R-type.
  - DBDataSrc=1 for lw.
  - WrRegDSrc=0 for jal, 1 otherwise.
  - PCSrc: 11 for j/jal, 10 for jr, 01 for beq with Zero=1 or bne with Zero=0, 00 otherwise.
- State-gated strobes (0 outside the listed cases):
  - IRWre=1 in IF.
  - PCWre=1 in ID for j/jal/jr/illegal, in bEXE, in aWB, in MEM for sw, and in cWB. Never for halt.
  - RegWre=1 in aWB, in cWB, and in ID for jal.
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- Illegal encodings are treated as NOP: PC advances by 4, no register or memory write.

## Timing
- RST low forces CurState=IF immediately, independent of CLK.
- While in reset: IRWre=1, InsMemRW=1, all other strobes 0; decoded selects follow the inputs.
- CurState<=NextState on each rising CLK edge while RST is high.
- All outputs other than CurState are combinational.
- ALU latency is 0 cycles.
- Cycles per instruction:
  - j, jal, jr: 2.
  - beq, bne: 3.
  - sw: 4.
  - R-type, I-type ALU ops: 4.
  - lw: 5.
  - halt: stalls in IF indefinitely; only reset leaves it.
- Reset asserted mid-instruction returns to IF asynchronously; a pending write strobe drops in the same instant.

## Test plan
- Reset, then add (OpCode 000000, Funct 100000), A=5, B=7 → states IF, ID, aEXE, aWB, IF. Y=12. RegWre=1 and PCWre=1 only in aWB. RegDst=10.
- lw (100011), A=0x100, B=4 → path IF, ID, sEXE, MEM, cWB. Y=0x104. mRD=1 in MEM. DBDataSrc=1. RegWre=1 in cWB.
- beq (000100), A=B=9 → Zero=1, PCSrc=01, PCWre=1 in bEXE. Same with B=8 → PCSrc=00.
- jal (000011) → ID→IF. RegWre=1, PCWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, all in ID.
- ALU sweep:
  - sll with A=4, B=1 → Y=16.
  - slt with A=0xFFFFFFFF, B=1 → Y=1; ALUOp 111 with the same operands → Y=0.
  - sub with A=0, B=1 → Y=0xFFFFFFFF.
- halt (111111) → CurState stays 000 over 10 clocks with PCWre=0. Assert RST low during aEXE → CurState=000 before the next edge.
